// File: rtl/onchip_loader_pkg.sv
// Shared definitions for the on-chip memory stream loader.
// Contents:
//   DEPTH_DEFAULT  default RAM depth in 32-bit words
//   WORD_W         RAM data width
//   LANES          byte lanes per RAM word
//   loader_state_e loader FSM encoding (idle / filling / overflowed)
//   lane_mask()    byteenable covering lanes 0..lane inclusive
package onchip_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT = 2250;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned LANES         = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StOvf  = 2'd2
    } loader_state_e;

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] lane);
        logic [LANES-1:0] mask;
        case (lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/onchip_mem_byte_packer.sv
// Byte-to-word packer for the stream loader.
// Collects bytes into little-endian 32-bit words: byte k of a word lands in lane k.
// The completed word is presented combinationally in the same cycle as the byte that
// completes it (lane 3 filled, or the last byte of a packet), and packing of the next word
// starts immediately, so the owner can register it straight into the RAM strobes.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   push         accept in_byte this cycle
//   restart      discard any partial word; in_byte goes to lane 0
//   last         in_byte ends the packet; flush whatever is filled
//   in_byte      data byte
//   word_valid   a word is complete this cycle
//   word         completed word, unfilled lanes zero
//   be           lanes filled in word
module onchip_mem_byte_packer
    import onchip_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              restart,
    input  logic              last,
    input  logic [7:0]        in_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [LANES-1:0]  be
);

    logic [1:0]        lane_q, lane_d, base_lane;
    logic [WORD_W-1:0] accum_q, accum_d, base_word;

    always_comb begin
        base_lane  = restart ? 2'd0 : lane_q;
        base_word  = restart ? '0 : accum_q;
        word       = base_word | (WORD_W'(in_byte) << {base_lane, 3'b000});
        be         = lane_mask(base_lane);
        word_valid = push & ((base_lane == 2'd3) | last);

        lane_d  = lane_q;
        accum_d = accum_q;
        if (push) begin
            if (word_valid) begin
                lane_d  = 2'd0;
                accum_d = '0;
            end else begin
                lane_d  = base_lane + 2'd1;
                accum_d = word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q  <= 2'd0;
            accum_q <= '0;
        end else begin
            lane_q  <= lane_d;
            accum_q <= accum_d;
        end
    end

endmodule

// File: rtl/onchip_memory_stream_loader.sv
// Avalon-ST byte sink that packs a packet into 32-bit little-endian words and writes them
// from address 0 upward into a single-port on-chip RAM through its Avalon-MM s1 pins.
// Always ready; one byte per clock; one registered write strobe per completed word.
// Words that would land at address DEPTH or beyond are not written: the packet is marked
// overflowed and the rest of it is dropped until the next start-of-packet.
// Optional feature: define LOADER_CHECKSUM_EN to add checksum[15:0], the mod-2^16 sum of
// every byte of the current packet (including bytes dropped after overflow).
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   in_data/in_valid/in_sop/in_eop/in_ready   Avalon-ST byte sink
//   mem_address/mem_byteenable/mem_chipselect/mem_write/mem_writedata/mem_clken  RAM s1
//   done             one-clk pulse the clock after the packet's final write
//   overflow         sticky: packet exceeded DEPTH words; cleared by next SOP
//   word_count       words written in current/last packet
//   checksum         (LOADER_CHECKSUM_EN only) byte sum of current packet
module onchip_memory_stream_loader
    import onchip_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LANES-1:0]  mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    // One extra bit so the count can reach DEPTH even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    loader_state_e state_q, state_d;

    logic              accept, start, push;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [LANES-1:0]  be;
    logic [ADDR_W:0]   count_q, cur_count;
    logic              issue, ovf_hit;

    logic              mem_write_q, last_write_q, done_q, overflow_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [LANES-1:0]  mem_be_q;
    logic [WORD_W-1:0] mem_data_q;

    onchip_mem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .restart    (start),
        .last       (in_eop),
        .in_byte    (in_data),
        .word_valid (word_valid),
        .word       (word),
        .be         (be)
    );

    always_comb begin
        accept    = in_valid;
        start     = accept & in_sop;
        push      = start | (accept & (state_q == StFill));
        // SOP restarts addressing in the same cycle, so a single-byte packet writes at 0.
        cur_count = start ? '0 : count_q;
        issue     = word_valid & (cur_count < DepthCnt);
        ovf_hit   = word_valid & ~issue;

        state_d = state_q;
        if (start) begin
            state_d = in_eop ? StIdle : StFill;
        end else begin
            case (state_q)
                StFill: begin
                    if (ovf_hit) begin
                        state_d = StOvf;
                    end else if (accept & in_eop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            mem_write_q   <= 1'b0;
            last_write_q  <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            mem_address_q <= '0;
            mem_be_q      <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            mem_write_q  <= issue;
            last_write_q <= issue & in_eop;
            done_q       <= last_write_q;
            if (issue) begin
                mem_address_q <= cur_count[ADDR_W-1:0];
                mem_data_q    <= word;
                mem_be_q      <= be;
                count_q       <= cur_count + 1'b1;
            end else if (start) begin
                mem_address_q <= '0;
                count_q       <= '0;
            end
            if (start) begin
                overflow_q <= 1'b0;
            end else if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start) begin
            csum_q <= {8'd0, in_data};
        end else if (accept && (state_q != StIdle)) begin
            csum_q <= csum_q + {8'd0, in_data};
        end
    end

    assign checksum = csum_q;
`endif

    assign in_ready       = 1'b1;
    assign mem_clken      = 1'b1;
    assign mem_write      = mem_write_q;
    assign mem_chipselect = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_be_q;
    assign mem_writedata  = mem_data_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign word_count     = count_q[ADDR_W-1:0];

endmodule

// File: tb/tb_onchip_memory_stream_loader.sv
module tb_onchip_memory_stream_loader;

    localparam int DEPTH = 2250;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid, in_sop, in_eop, in_ready;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic        done, overflow;
    logic [11:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] csum_at_done;
`endif

    onchip_memory_stream_loader #(
        .ADDR_W (12),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_ready       (in_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .done           (done),
        .overflow       (overflow),
        .word_count     (word_count)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [7:0]  pkt[$];
    int          done_cnt, done_cyc, last_wr_cyc;
    logic [11:0] wc_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the RAM port and done away from the active edge.
    always @(negedge clk) begin
        if (mem_write) begin
            obs_q.push_back({mem_address, mem_writedata, mem_byteenable});
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc   = cyc;
            wc_at_done = word_count;
`ifdef LOADER_CHECKSUM_EN
            csum_at_done = checksum;
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sop, input bit eop, input bit gaps);
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_valid = 1'b1;
        idle(1);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'($urandom);
        if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2));
    endtask

    task automatic send_pkt(input bit eop, input bit gaps);
        for (int i = 0; i < pkt.size(); i++) begin
            send(pkt[i], i == 0, eop && (i == pkt.size() - 1), gaps);
        end
    endtask

    // Reference: consecutive groups of 4 bytes form little-endian words at addresses 0,1,..;
    // a trailing partial group is written only if the packet ended; words at >= DEPTH are lost.
    task automatic model(input bit eop, output int n_wr, output bit ovf);
        int n, nwords;
        logic [31:0] d;
        logic [3:0]  b;
        n      = pkt.size();
        nwords = eop ? (n + 3) / 4 : n / 4;
        n_wr   = 0;
        for (int w = 0; w < nwords; w++) begin
            if (w < DEPTH) begin
                d = '0;
                b = '0;
                for (int l = 0; l < 4; l++) begin
                    if (4 * w + l < n) begin
                        d[8*l +: 8] = pkt[4*w+l];
                        b[l]        = 1'b1;
                    end
                end
                exp_q.push_back({12'(w), d, b});
                n_wr++;
            end
        end
        ovf = nwords > DEPTH;
    endtask

    task automatic run_pkt(input string tag, input bit eop, input bit gaps);
        int  n_wr;
        bit  ovf;
        bit  exp_done;
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        model(eop, n_wr, ovf);
        send_pkt(eop, gaps);
        idle(4);
        check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                check($sformatf("%s_write%0d", tag, i), obs_q[i], exp_q[i]);
                break;
            end
        end
        if (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_lastwrite"}, obs_q[obs_q.size()-1], exp_q[exp_q.size()-1]);
        exp_done = eop && !ovf;
        check({tag, "_done_cnt"}, done_cnt, exp_done ? 1 : 0);
        if (exp_done) begin
            check({tag, "_done_lat"}, done_cyc - last_wr_cyc, 1);
            check({tag, "_wc_at_done"}, wc_at_done, n_wr);
        end
        check({tag, "_overflow"}, overflow, ovf);
        check({tag, "_word_count"}, word_count, n_wr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_chipselect"}, mem_chipselect, 0);
        check({tag, "_address"}, mem_address, 0);
        check({tag, "_byteenable"}, mem_byteenable, 0);
        check({tag, "_writedata"}, mem_writedata, 0);
        check({tag, "_clken"}, mem_clken, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h00;
        idle(3);
        reset = 1'b0;
        idle(1);
        check_reset_values("rst");

        // 8-byte packet 01..08
        pkt.delete();
        for (int i = 1; i <= 8; i++) pkt.push_back(8'(i));
        run_pkt("p8", 1, 0);

        // 5-byte packet AA..EE
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_pkt("p5", 1, 0);

        // single-byte packet: SOP and EOP together
        pkt = '{8'h5A};
        run_pkt("p1", 1, 0);

        // random packets with random gaps
        for (int k = 0; k < 8; k++) begin
            pkt.delete();
            repeat ($urandom_range(1, 40)) pkt.push_back(8'($urandom));
            run_pkt($sformatf("rnd%0d", k), 1, 1);
        end

        // SOP after 6 bytes: only the first full word is written, partial is discarded
        pkt.delete();
        repeat (6) pkt.push_back(8'($urandom));
        run_pkt("mid_a", 0, 0);
        pkt.delete();
        repeat (7) pkt.push_back(8'($urandom));
        run_pkt("mid_b", 1, 0);

        // DEPTH+1 words: last write at DEPTH-1, overflow, no done
        pkt.delete();
        repeat (4 * (DEPTH + 1)) pkt.push_back(8'($urandom));
        run_pkt("ovf", 1, 0);
        check("ovf_last_addr", obs_q.size() > 0 ? obs_q[obs_q.size()-1].a : 12'hFFF, DEPTH - 1);

        // next SOP clears overflow and writes at 0
        pkt.delete();
        repeat (6) pkt.push_back(8'($urandom));
        run_pkt("after_ovf", 1, 1);

        // reset for one clock mid-packet, then bytes without SOP are dropped
        pkt.delete();
        repeat (3) pkt.push_back(8'($urandom));
        send_pkt(0, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        obs_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 6; i++) send(8'($urandom), 0, i == 5, 0);
        idle(3);
        check("rstmid_nwrites", obs_q.size(), 0);
        check("rstmid_done_cnt", done_cnt, 0);
        check_reset_values("rstmid");

`ifdef LOADER_CHECKSUM_EN
        pkt.delete();
        repeat (256) pkt.push_back(8'hFF);
        run_pkt("csum", 1, 0);
        check("csum_at_done", csum_at_done, 16'hFF00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
